// File: rtl/nrisc_ctrl.sv
// Multi-cycle control FSM for a tiny 8-bit RISC: fetch/decode/execute/memory/
// writeback sequencing, PC management and registered control outputs.
module nrisc_ctrl #(
  parameter int unsigned         PC_W     = 8,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      alu_ctl,
  input  logic            alu_zero,
  output logic [1:0]      rs_sel,
  output logic [1:0]      rt_sel,
  output logic            reg_we,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_SLT  = 4'b0000,
    OP_MOV  = 4'b0010,
    OP_INC  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_ADD  = 4'b0111,
    OP_LW   = 4'b1000,
    OP_SW   = 4'b1001,
    OP_SEQ  = 4'b1010,
    OP_HALT = 4'b1111
  } opcode_t;

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [3:0]      r_alu_ctl;
  logic [1:0]      r_rs_sel;
  logic [1:0]      r_rt_sel;
  logic            r_imem_req;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic            r_reg_we;
  logic            r_halted;

  logic [3:0]      w_op;
  logic [3:0]      w_dec_alu;
  logic            w_is_alu;
  logic            w_is_mem;
  logic            w_is_sw;
  logic            w_is_seq;
  logic            w_is_halt;
  logic            w_is_nop;
  logic            w_fetch_ok;

  assign w_op       = r_ir[7:4];
  assign w_fetch_ok = r_imem_req && imem_ack;

  always_comb begin
    w_dec_alu = 4'hF;
    w_is_alu  = 1'b0;
    w_is_mem  = 1'b0;
    w_is_sw   = 1'b0;
    w_is_seq  = 1'b0;
    w_is_halt = 1'b0;
    case (w_op)
      OP_SLT:  begin w_dec_alu = 4'd0; w_is_alu = 1'b1; end
      OP_MOV:  begin w_dec_alu = 4'd2; w_is_alu = 1'b1; end
      OP_INC:  begin w_dec_alu = 4'd4; w_is_alu = 1'b1; end
      OP_SUB:  begin w_dec_alu = 4'd5; w_is_alu = 1'b1; end
      OP_ADD:  begin w_dec_alu = 4'd7; w_is_alu = 1'b1; end
      OP_LW:   begin w_dec_alu = 4'd2; w_is_mem = 1'b1; end
      OP_SW:   begin w_dec_alu = 4'd2; w_is_mem = 1'b1; w_is_sw = 1'b1; end
      OP_SEQ:  begin w_dec_alu = 4'd5; w_is_seq = 1'b1; end
      OP_HALT: w_is_halt = 1'b1;
      default: w_dec_alu = 4'hF;
    endcase
    w_is_nop = !(w_is_alu || w_is_mem || w_is_seq || w_is_halt);
  end

  // A fetch is only accepted once imem_req is visible, so the first cycle
  // after reset never consumes an ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_fetch_ok) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_halt)     w_next = S_HALT;
        else if (w_is_nop) w_next = S_FETCH;
        else               w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_alu)       w_next = S_WB;
        else if (w_is_mem)  w_next = S_MEM;
        else if (w_is_halt) w_next = S_HALT;
        else                w_next = S_FETCH;
      end
      S_MEM:    if (dmem_ack) w_next = w_is_sw ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Request/enable outputs are registered from the next state so each one
  // is valid for the whole cycle spent in its owning state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_alu_ctl  <= '1;
      r_rs_sel   <= '0;
      r_rt_sel   <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_reg_we   <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_imem_req <= (w_next == S_FETCH);
      r_dmem_req <= (w_next == S_MEM);
      r_dmem_we  <= (w_next == S_MEM) && w_is_sw;
      r_reg_we   <= (w_next == S_WB);
      r_halted   <= (w_next == S_HALT);
      if (r_state == S_FETCH && w_fetch_ok) begin
        r_ir <= imem_rdata;
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == S_EXEC && w_is_seq && alu_zero) begin
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == S_DECODE) begin
        r_rs_sel <= r_ir[3:2];
        r_rt_sel <= r_ir[1:0];
      end
      case (w_next)
        S_EXEC, S_MEM, S_WB: if (r_state == S_DECODE) r_alu_ctl <= w_dec_alu;
        default:             r_alu_ctl <= '1;
      endcase
    end
  end

  assign imem_req = r_imem_req;
  assign pc       = r_pc;
  assign alu_ctl  = r_alu_ctl;
  assign rs_sel   = r_rs_sel;
  assign rt_sel   = r_rt_sel;
  assign reg_we   = r_reg_we;
  assign dmem_req = r_dmem_req;
  assign dmem_we  = r_dmem_we;
  assign halted   = r_halted;
  assign state    = r_state;

endmodule
